// File: rtl/ksa_pipe.sv
// ksa_pipe: three-stage Kogge-Stone adder/subtractor
// with valid/ready handshake and global stall.
module ksa_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int LVL = $clog2(WIDTH);

  logic             stall;
  logic             take;
  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] g0;
  logic [WIDTH-1:0] p0;
  logic             c0;

  logic             v1;
  logic [WIDTH-1:0] g1;
  logic [WIDTH-1:0] p1;
  logic             cz1;

  logic             v2;
  logic [WIDTH-1:0] c2;
  logic [WIDTH-1:0] p2;
  logic             cz2;

  logic [WIDTH-1:0] gg;
  logic [WIDTH-1:0] pp;
  logic [WIDTH-1:0] gn;
  logic [WIDTH-1:0] pn;
  logic [WIDTH-1:0] s3;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;
  assign take     = in_valid && in_ready;

  // operand conditioning and bitwise generate/propagate
  always_comb begin
    bx    = sub ? ~b : b;
    c0    = sub ? 1'b1 : cin;
    p0    = a ^ bx;
    g0    = a & bx;
    g0[0] = (a[0] & bx[0]) | (p0[0] & c0);
  end

  // log-depth prefix tree; gg[i] ends as carry out of bit i
  always_comb begin
    gg = g1;
    pp = p1;
    gn = g1;
    pn = p1;
    for (int k = 0; k < LVL; k++) begin
      gn = gg;
      pn = pp;
      for (int i = 0; i < WIDTH; i++) begin
        if (i >= (1 << k)) begin
          gn[i] = gg[i] | (pp[i] & gg[i - (1 << k)]);
          pn[i] = pp[i] & pp[i - (1 << k)];
        end
      end
      gg = gn;
      pp = pn;
    end
  end

  // final sum from propagate and shifted-in carries
  always_comb begin
    s3 = p2 ^ {c2[WIDTH-2:0], cz2};
  end

  // stage 1: capture g/p only on acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1  <= 1'b0;
      g1  <= '0;
      p1  <= '0;
      cz1 <= 1'b0;
    end else if (!stall) begin
      v1 <= take;
      if (take) begin
        g1  <= g0;
        p1  <= p0;
        cz1 <= c0;
      end
    end
  end

  // stage 2: register prefix carries
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2  <= 1'b0;
      c2  <= '0;
      p2  <= '0;
      cz2 <= 1'b0;
    end else if (!stall) begin
      v2  <= v1;
      c2  <= gg;
      p2  <= p1;
      cz2 <= cz1;
    end
  end

  // stage 3: register sum and flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (!stall) begin
      out_valid <= v2;
      sum       <= s3;
      cout      <= c2[WIDTH-1];
      ovf       <= c2[WIDTH-1] ^ c2[WIDTH-2];
      zero      <= ~|s3;
    end
  end

endmodule

// File: tb/tb_ksa_pipe.sv
// tb_ksa_pipe: directed and random checks of ksa_pipe
// at widths 2, 8, 13, 16 and 64 against an arithmetic model.
module tb_ksa_pipe;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        sub;
  } item_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [63:0] opa = '0;
  logic [63:0] opb = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;

  logic        ir2, ov2, co2, of2, z2;
  logic [1:0]  s2;
  logic        ir8, ov8, co8, of8, z8;
  logic [7:0]  s8;
  logic        ir13, ov13, co13, of13, z13;
  logic [12:0] s13;
  logic        ir16, ov16, co16, of16, z16;
  logic [15:0] s16;
  logic        ir64, ov64, co64, of64, z64;
  logic [63:0] s64;

  int    ncmp = 0;
  int    nbad = 0;
  int    nacc = 0;
  int    ndel = 0;
  int    nstall = 0;
  item_t q[$];
  item_t e;
  item_t it;
  logic  pstall = 1'b0;
  logic [19:0] pout;
  bit    rmode = 0;
  bit    bp_arm = 0;
  int    bp_left = 0;
  int    d0, st0;

  always #5 clk = ~clk;

  ksa_pipe #(.WIDTH(2)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2),
    .a(opa[1:0]), .b(opb[1:0]), .cin(cin), .sub(sub),
    .out_valid(ov2), .out_ready(out_ready), .sum(s2),
    .cout(co2), .ovf(of2), .zero(z2));

  ksa_pipe #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir8),
    .a(opa[7:0]), .b(opb[7:0]), .cin(cin), .sub(sub),
    .out_valid(ov8), .out_ready(out_ready), .sum(s8),
    .cout(co8), .ovf(of8), .zero(z8));

  ksa_pipe #(.WIDTH(13)) u13 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir13),
    .a(opa[12:0]), .b(opb[12:0]), .cin(cin), .sub(sub),
    .out_valid(ov13), .out_ready(out_ready), .sum(s13),
    .cout(co13), .ovf(of13), .zero(z13));

  ksa_pipe #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir16),
    .a(opa[15:0]), .b(opb[15:0]), .cin(cin), .sub(sub),
    .out_valid(ov16), .out_ready(out_ready), .sum(s16),
    .cout(co16), .ovf(of16), .zero(z16));

  ksa_pipe #(.WIDTH(64)) u64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir64),
    .a(opa), .b(opb), .cin(cin), .sub(sub),
    .out_valid(ov64), .out_ready(out_ready), .sum(s64),
    .cout(co64), .ovf(of64), .zero(z64));

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    ncmp++;
    if (obs !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // arithmetic reference: integer add of a, b or ~b, carry-in
  task automatic cmp(int w, logic [63:0] s, logic co, logic ov,
                     logic z, item_t x);
    logic [63:0] m, aa, bb, es;
    logic [64:0] full;
    logic        ec, eo;
    m    = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    aa   = x.a & m;
    bb   = (x.sub ? ~x.b : x.b) & m;
    full = {1'b0, aa} + {1'b0, bb} + 65'(x.sub ? 1'b1 : x.cin);
    es   = full[63:0] & m;
    ec   = full[w];
    eo   = (aa[w-1] == bb[w-1]) && (es[w-1] != aa[w-1]);
    check($sformatf("sum_w%0d", w), s, es);
    check($sformatf("cout_w%0d", w), 64'(co), 64'(ec));
    check($sformatf("ovf_w%0d", w), 64'(ov), 64'(eo));
    check($sformatf("zero_w%0d", w), 64'(z), 64'(es == 0));
  endtask

  // scoreboard and handshake monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      nacc   = ndel;
      pstall = 1'b0;
    end else begin
      check("in_ready", 64'(ir16), 64'(!(ov16 && !out_ready)));
      check("rdy_eq", {ir2, ir8, ir13, ir64}, {4{ir16}});
      check("ov_eq", {ov2, ov8, ov13, ov64}, {4{ov16}});
      if (pstall)
        check("hold", {ov16, co16, of16, z16, s16}, {1'b1, pout[18:0]});
      if (ov16 && !out_ready) nstall++;
      if (ov16 && out_ready) begin
        if (q.size() == 0) begin
          check("underflow", 1, 0);
        end else begin
          e = q.pop_front();
          ndel++;
          cmp(2, 64'(s2), co2, of2, z2, e);
          cmp(8, 64'(s8), co8, of8, z8, e);
          cmp(13, 64'(s13), co13, of13, z13, e);
          cmp(16, 64'(s16), co16, of16, z16, e);
          cmp(64, s64, co64, of64, z64, e);
        end
      end
      if (in_valid && ir16) begin
        it.a = opa;
        it.b = opb;
        it.cin = cin;
        it.sub = sub;
        q.push_back(it);
        nacc++;
      end
      pstall = ov16 && !out_ready;
      pout   = {ov16, co16, of16, z16, s16};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rmode) begin
      out_ready = ($urandom_range(0, 3) != 0);
    end else if (bp_arm && ov16) begin
      bp_arm    = 0;
      out_ready = 1'b0;
      bp_left   = 5;
    end else if (bp_left > 0) begin
      bp_left--;
      if (bp_left == 0) out_ready = 1'b1;
    end
  endtask

  task automatic send(logic [63:0] x, logic [63:0] y,
                      logic ci, logic su);
    bit acc;
    opa = x;
    opb = y;
    cin = ci;
    sub = su;
    in_valid = 1'b1;
    acc = 0;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk);
      acc = ir16;
      tick();
    end
    if (!acc) check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic lat(string tag, logic [15:0] x, logic [15:0] y,
                     logic ci, logic su, logic [15:0] es,
                     logic eco, logic eov, logic ez);
    opa = 64'(x);
    opb = 64'(y);
    cin = ci;
    sub = su;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check({tag, "_lat1"}, 64'(ov16), 0);
    @(posedge clk);
    #1;
    check({tag, "_lat2"}, 64'(ov16), 0);
    @(posedge clk);
    #1;
    check({tag, "_lat3"}, 64'(ov16), 1);
    check({tag, "_res"}, {co16, of16, z16, s16}, {eco, eov, ez, es});
    tick();
  endtask

  initial begin
    #1;
    check("rst_ov", 64'(ov16), 0);
    check("rst_rdy", 64'(ir16), 1);
    check("rst_out", {co16, of16, z16, s16}, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    lat("t1", 16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0, 1);
    lat("t2", 16'h7FFF, 16'h0001, 1, 0, 16'h8001, 0, 1, 0);
    lat("t3", 16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1, 0);
    lat("t4", 16'h0005, 16'h0007, 1, 1, 16'hFFFE, 0, 0, 0);

    d0  = ndel;
    st0 = nstall;
    bp_arm = 1;
    for (int i = 1; i <= 6; i++) send(64'(i), 64'h10, 0, 0);
    for (int t = 0; t < 30 && q.size() > 0; t++) tick();
    tick();
    check("bp_count", 64'(ndel - d0), 6);
    check("bp_stalls", 64'(nstall - st0), 5);
    check("bp_empty", 64'(q.size()), 0);

    for (int i = 1; i <= 3; i++) send(64'(i), 64'h20, 0, 0);
    check("mid_pre", 64'(ov16), 1);
    rst = 1'b1;
    #1;
    check("mid_ov", 64'(ov16), 0);
    check("mid_rdy", 64'(ir16), 1);
    check("mid_out", {co16, of16, z16, s16}, 0);
    tick();
    tick();
    rst = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tick();
      check("no_stale", 64'(ov16), 0);
    end
    lat("t5", 16'h0002, 16'h0003, 0, 0, 16'h0005, 0, 0, 0);

    rmode = 1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 4) == 0) tick();
      send({$urandom, $urandom}, {$urandom, $urandom},
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    rmode = 0;
    out_ready = 1'b1;
    for (int t = 0; t < 50 && q.size() > 0; t++) tick();
    tick();
    check("rnd_empty", 64'(q.size()), 0);
    check("rnd_count", 64'(ndel), 64'(nacc));
    check("end_ov", 64'(ov16), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
